// File: rtl/addr_rf_scheduler.sv
// addr_rf_scheduler: walks every output position (h, w) of a tile at the
// configured stride. At each position it walks every weight column, and for
// each column it starts the address/RF engine, waits for the engine to
// finish, and hands the result to the consumer over a valid/ready handshake.
//
// Optional build macro: ADDR_RF_SCHED_SKIP_EMPTY_EN
//   When defined, a column whose length is zero is not issued. It costs one
//   ISSUE cycle and then goes straight to the next job.
//   When undefined, every column is issued, including zero-length ones.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | waiting for i_start; config is latched when it arrives
// ISSUE  | one cycle: pulse the engine start for the current (h, w, col)
// WAIT   | waiting for i_eng_finish
// OUT    | o_out_valid held until the consumer accepts; then advance
// DONE   | one-cycle o_done pulse, then back to IDLE
module addr_rf_scheduler #(
    parameter int ROW_W   = 7,
    parameter int COL_NUM = 8,
    parameter int LEN_W   = 5,
    localparam int COL_W  = $clog2(COL_NUM)
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_start,
    input  logic                     i_abort,
    input  logic [ROW_W-1:0]         i_height,
    input  logic [ROW_W-1:0]         i_width,
    input  logic [1:0]               i_stride,
    input  logic [COL_NUM*LEN_W-1:0] i_col_len,
    output logic                     o_busy,
    output logic                     o_done,
    output logic                     o_eng_start,
    output logic [ROW_W-1:0]         o_eng_h,
    output logic [ROW_W-1:0]         o_eng_w,
    output logic [1:0]               o_eng_s,
    output logic [LEN_W-1:0]         o_eng_length,
    output logic [COL_W-1:0]         o_eng_col,
    input  logic                     i_eng_finish,
    output logic                     o_out_valid,
    input  logic                     i_out_ready
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_OUT   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t state_q, state_d;

    logic [ROW_W-1:0]         height_q;
    logic [ROW_W-1:0]         width_q;
    logic [1:0]               stride_q;
    logic [COL_NUM*LEN_W-1:0] col_len_q;
    logic [ROW_W-1:0]         h_q;
    logic [ROW_W-1:0]         w_q;
    logic [COL_W-1:0]         col_q;
    logic [LEN_W-1:0]         len_q;

    logic [LEN_W-1:0] col_len_arr [COL_NUM];
    logic [ROW_W:0]   h_sum;
    logic [ROW_W:0]   w_sum;
    logic             h_more;
    logic             w_more;
    logic             col_last;
    logic             tile_last;
    logic [COL_W-1:0] col_nxt;
    logic             adv_en;
    logic [1:0]       stride_norm;

`ifdef ADDR_RF_SCHED_SKIP_EMPTY_EN
    logic job_empty;
    assign job_empty = (len_q == '0);
`endif

    // One extra bit on the sums so w+s / h+s never wrap past the coordinate width.
    assign h_sum       = {1'b0, h_q} + {{(ROW_W-1){1'b0}}, stride_q};
    assign w_sum       = {1'b0, w_q} + {{(ROW_W-1){1'b0}}, stride_q};
    assign h_more      = (h_sum < {1'b0, height_q});
    assign w_more      = (w_sum < {1'b0, width_q});
    assign col_last    = (col_q == COL_W'(COL_NUM - 1));
    assign tile_last   = col_last && !w_more && !h_more;
    assign col_nxt     = col_last ? '0 : col_q + COL_W'(1);
    assign stride_norm = (i_stride == 2'd0) ? 2'd1 : i_stride;

`ifdef ADDR_RF_SCHED_SKIP_EMPTY_EN
    assign adv_en = ((state_q == S_OUT) && i_out_ready) ||
                    ((state_q == S_ISSUE) && job_empty);
`else
    assign adv_en = (state_q == S_OUT) && i_out_ready;
`endif

    // Unpack the latched per-column lengths so the next column can be selected.
    always_comb begin
        for (int c = 0; c < COL_NUM; c++) begin
            col_len_arr[c] = col_len_q[c*LEN_W +: LEN_W];
        end
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; abort overrides every transition.
    always_comb begin
        state_d = state_q;
        if (i_abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (i_start) begin
                        state_d = ((i_height == '0) || (i_width == '0)) ? S_DONE : S_ISSUE;
                    end
                end
                S_ISSUE: begin
`ifdef ADDR_RF_SCHED_SKIP_EMPTY_EN
                    if (job_empty) begin
                        state_d = tile_last ? S_DONE : S_ISSUE;
                    end else begin
                        state_d = S_WAIT;
                    end
`else
                    state_d = S_WAIT;
`endif
                end
                S_WAIT: begin
                    if (i_eng_finish) begin
                        state_d = S_OUT;
                    end
                end
                S_OUT: begin
                    if (i_out_ready) begin
                        state_d = tile_last ? S_DONE : S_ISSUE;
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Moore outputs decoded from the current state.
    always_comb begin
        o_busy      = 1'b0;
        o_done      = 1'b0;
        o_eng_start = 1'b0;
        o_out_valid = 1'b0;
        case (state_q)
            S_ISSUE: begin
                o_busy = 1'b1;
`ifdef ADDR_RF_SCHED_SKIP_EMPTY_EN
                o_eng_start = !job_empty;
`else
                o_eng_start = 1'b1;
`endif
            end
            S_WAIT: o_busy = 1'b1;
            S_OUT: begin
                o_busy      = 1'b1;
                o_out_valid = 1'b1;
            end
            S_DONE:  o_done = 1'b1;
            default: ;
        endcase
    end

    // Config latch and (h, w, col) walk; a column step also reloads the length.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            height_q  <= '0;
            width_q   <= '0;
            stride_q  <= '0;
            col_len_q <= '0;
            h_q       <= '0;
            w_q       <= '0;
            col_q     <= '0;
            len_q     <= '0;
        end else if (i_abort) begin
            h_q <= h_q;
        end else if ((state_q == S_IDLE) && i_start) begin
            height_q  <= i_height;
            width_q   <= i_width;
            stride_q  <= stride_norm;
            col_len_q <= i_col_len;
            h_q       <= '0;
            w_q       <= '0;
            col_q     <= '0;
            len_q     <= i_col_len[LEN_W-1:0];
        end else if (adv_en) begin
            col_q <= col_nxt;
            len_q <= col_len_arr[col_nxt];
            if (col_last) begin
                if (w_more) begin
                    w_q <= w_sum[ROW_W-1:0];
                end else begin
                    w_q <= '0;
                    if (h_more) begin
                        h_q <= h_sum[ROW_W-1:0];
                    end
                end
            end
        end
    end

    assign o_eng_h      = h_q;
    assign o_eng_w      = w_q;
    assign o_eng_s      = stride_q;
    assign o_eng_length = len_q;
    assign o_eng_col    = col_q;

endmodule

// File: tb/tb_addr_rf_scheduler.sv
// Directed bench for addr_rf_scheduler: a table of tiles that are run against
// an engine/consumer model, plus hand-written abort and reset sequences.
module tb_addr_rf_scheduler;

    localparam int ROW_W   = 7;
    localparam int COL_NUM = 4;
    localparam int LEN_W   = 5;
    localparam int COL_W   = 2;
    localparam int LW      = COL_NUM * LEN_W;

    logic             clk = 1'b0;
    logic             i_rst = 1'b1;
    logic             i_start = 1'b0;
    logic             i_abort = 1'b0;
    logic [ROW_W-1:0] i_height = '0;
    logic [ROW_W-1:0] i_width = '0;
    logic [1:0]       i_stride = '0;
    logic [LW-1:0]    i_col_len = '0;
    logic             o_busy, o_done, o_eng_start, o_out_valid;
    logic [ROW_W-1:0] o_eng_h, o_eng_w;
    logic [1:0]       o_eng_s;
    logic [LEN_W-1:0] o_eng_length;
    logic [COL_W-1:0] o_eng_col;
    logic             i_eng_finish = 1'b0;
    logic             i_out_ready = 1'b1;

    addr_rf_scheduler #(.ROW_W(ROW_W), .COL_NUM(COL_NUM), .LEN_W(LEN_W)) dut (
        .i_clk(clk), .i_rst(i_rst), .i_start(i_start), .i_abort(i_abort),
        .i_height(i_height), .i_width(i_width), .i_stride(i_stride),
        .i_col_len(i_col_len), .o_busy(o_busy), .o_done(o_done),
        .o_eng_start(o_eng_start), .o_eng_h(o_eng_h), .o_eng_w(o_eng_w),
        .o_eng_s(o_eng_s), .o_eng_length(o_eng_length), .o_eng_col(o_eng_col),
        .i_eng_finish(i_eng_finish), .o_out_valid(o_out_valid),
        .i_out_ready(i_out_ready)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        int            h;
        int            w;
        int            s;
        logic [LW-1:0] lens;
        int            stall_job;
        int            fin;
        bit            poke;
        int            exp_jobs;
        int            exp_cyc;
    } vec_t;

    typedef struct {
        int h;
        int w;
        int c;
        int len;
    } job_t;

    vec_t vecs[$];

    function automatic vec_t mk(int h, int w, int s, logic [LW-1:0] lens, int stall_job,
                                int fin, bit poke, int exp_jobs, int exp_cyc);
        vec_t v;
        v.h = h; v.w = w; v.s = s; v.lens = lens; v.stall_job = stall_job;
        v.fin = fin; v.poke = poke; v.exp_jobs = exp_jobs; v.exp_cyc = exp_cyc;
        return v;
    endfunction

    // Runs one tile: start pulse, engine answering fin cycles after each
    // start, consumer optionally stalling 5 cycles on job stall_job.
    task automatic run_tile(input int idx, input vec_t v);
        job_t exp_q[$];
        job_t j;
        int ss, n_starts, n_hs, n_done, done_cyc, last_hs, cyc, eng_cnt, stall_left;
        bit running;
        logic [23:0] snap, now;
        logic [LEN_W-1:0] ln;
        ss = (v.s == 0) ? 1 : v.s;
        for (int h = 0; h < v.h; h += ss)
            for (int w = 0; w < v.w; w += ss)
                for (int c = 0; c < COL_NUM; c++) begin
                    ln = v.lens[c*LEN_W +: LEN_W];
`ifdef ADDR_RF_SCHED_SKIP_EMPTY_EN
                    if (ln == 0) continue;
`endif
                    j.h = h; j.w = w; j.c = c; j.len = int'(ln);
                    exp_q.push_back(j);
                end
        n_starts = 0; n_hs = 0; n_done = 0; done_cyc = -100; last_hs = -100;
        eng_cnt = 0; running = 0; stall_left = 5; snap = '0;
        i_height = ROW_W'(v.h); i_width = ROW_W'(v.w); i_stride = 2'(v.s);
        i_col_len = v.lens; i_start = 1'b1; i_out_ready = 1'b1; i_eng_finish = 1'b0;
        @(negedge clk);
        i_start = 1'b0;
        cyc = 1;
        for (int k = 0; k < 2000; k++) begin
            i_eng_finish = 1'b0;
            if (o_eng_start) begin
                if (n_starts < exp_q.size()) begin
                    j = exp_q[n_starts];
                    check($sformatf("v%0d_j%0d_h", idx, n_starts), o_eng_h, j.h);
                    check($sformatf("v%0d_j%0d_w", idx, n_starts), o_eng_w, j.w);
                    check($sformatf("v%0d_j%0d_col", idx, n_starts), o_eng_col, j.c);
                    check($sformatf("v%0d_j%0d_len", idx, n_starts), o_eng_length, j.len);
                    check($sformatf("v%0d_j%0d_s", idx, n_starts), o_eng_s, ss);
                end else begin
                    check($sformatf("v%0d_extra_start", idx), 1, 0);
                end
                n_starts++;
                eng_cnt = v.fin;
                running = 1;
            end else if (running) begin
                eng_cnt--;
                if (eng_cnt <= 0) begin
                    i_eng_finish = 1'b1;
                    running = 0;
                end
            end
            now = {o_eng_h, o_eng_w, o_eng_col, o_eng_length, o_eng_s, o_eng_start};
            if (o_out_valid && n_hs == v.stall_job && stall_left > 0) begin
                if (stall_left == 5) snap = {now[23:1], 1'b0};
                check($sformatf("v%0d_stall_stable", idx), now, snap);
                stall_left--;
                i_out_ready = 1'b0;
            end else begin
                i_out_ready = 1'b1;
            end
            if (o_out_valid && i_out_ready) begin
                n_hs++;
                last_hs = cyc;
            end
            if (o_done) begin
                n_done++;
                done_cyc = cyc;
                check($sformatf("v%0d_busy_in_done", idx), o_busy, 0);
            end
            i_start = v.poke && o_busy;
            if (n_done > 0 && cyc >= done_cyc + 3) break;
            @(negedge clk);
            cyc++;
        end
        i_start = 1'b0;
        i_out_ready = 1'b1;
        i_eng_finish = 1'b0;
        check($sformatf("v%0d_starts", idx), n_starts, v.exp_jobs);
        check($sformatf("v%0d_handshakes", idx), n_hs, v.exp_jobs);
        check($sformatf("v%0d_done_pulses", idx), n_done, 1);
        if (v.exp_jobs > 0)
            check($sformatf("v%0d_done_after_last_hs", idx), done_cyc, last_hs + 1);
        if (v.exp_cyc >= 0)
            check($sformatf("v%0d_done_cycle", idx), done_cyc, v.exp_cyc);
    endtask

    logic [LW-1:0] lens_a;
    logic [LW-1:0] lens_z;

    initial begin
        int starts, extra;
        lens_a = {5'd4, 5'd3, 5'd2, 5'd1};
        lens_z = {5'd2, 5'd0, 5'd0, 5'd3};
        //               H    W   s  lens    stall fin poke jobs cyc
        vecs.push_back(mk(2,   2,  1, lens_a, -1,   2,  1,   16,  -1));
        vecs.push_back(mk(5,   4,  2, lens_a, -1,   2,  0,   24,  -1));
        vecs.push_back(mk(5,   4,  0, lens_a, -1,   1,  0,   80,  -1));
        vecs.push_back(mk(2,   2,  1, lens_a,  2,   1,  0,   16,  -1));
        vecs.push_back(mk(1,   1,  1, lens_a, -1,   1,  0,    4,  13));
        vecs.push_back(mk(0,   3,  1, lens_a, -1,   1,  1,    0,   1));
        vecs.push_back(mk(3,   0,  1, lens_a, -1,   1,  0,    0,   1));
        vecs.push_back(mk(3,   3,  3, lens_a, -1,   1,  0,    4,  13));
        vecs.push_back(mk(1, 127,  3, lens_a, -1,   1,  0,  172, 517));
`ifdef ADDR_RF_SCHED_SKIP_EMPTY_EN
        vecs.push_back(mk(1,   1,  1, lens_z, -1,   1,  0,    2,   9));
        vecs.push_back(mk(2,   1,  1, '0,     -1,   1,  0,    0,  -1));
`else
        vecs.push_back(mk(1,   1,  1, lens_z, -1,   1,  0,    4,  13));
`endif

        // Reset state
        i_rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_outputs",
              {o_busy, o_done, o_eng_start, o_out_valid, o_eng_h, o_eng_w,
               o_eng_s, o_eng_length, o_eng_col}, 0);
        i_rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < vecs.size(); i++) run_tile(i, vecs[i]);

        // Abort in WAIT of the 4th job
        i_height = 7'd2; i_width = 7'd2; i_stride = 2'd1; i_col_len = lens_a;
        i_eng_finish = 1'b1; i_out_ready = 1'b1; i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        starts = 0;
        for (int k = 0; k < 50; k++) begin
            if (o_eng_start) starts++;
            else if (starts == 4 && o_busy && !o_out_valid) break;
            @(negedge clk);
        end
        check("abort_reached_job4", starts, 4);
        i_abort = 1'b1;
        @(negedge clk);
        i_abort = 1'b0;
        i_eng_finish = 1'b0;
        check("abort_outputs", {o_busy, o_done, o_eng_start, o_out_valid}, 0);
        extra = 0;
        repeat (4) begin
            @(negedge clk);
            extra += int'(o_done) + int'(o_eng_start) + int'(o_busy);
        end
        check("abort_quiet_after", extra, 0);
        run_tile(100, mk(1, 2, 1, lens_a, -1, 1, 0, 8, 25));

        // Synchronous reset mid-tile clears the latched config and coordinates
        i_height = 7'd5; i_width = 7'd4; i_stride = 2'd2; i_col_len = lens_a;
        i_eng_finish = 1'b0; i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        check("rst_mid_issue", o_eng_start, 1);
        @(negedge clk);
        check("rst_mid_wait_s", o_eng_s, 2);
        i_rst = 1'b1;
        @(negedge clk);
        i_rst = 1'b0;
        check("rst_mid_outputs",
              {o_busy, o_done, o_eng_start, o_out_valid, o_eng_h, o_eng_w,
               o_eng_s, o_eng_length, o_eng_col}, 0);
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
